// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter.
//   arb_state_t : arbiter FSM states, IDLE through GAP
//   cnt_width() : width of the shared cycle counter, sized for the largest
//                 of the command hold, gap and watchdog limits
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_DONE,
        ST_GAP
    } arb_state_t;

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index; the search starts here and wraps
//   gnt   : one-hot grant (zero when no request)
//   idx   : index of the granted bit
//   valid : at least one request present
module spi_arb_rr #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        logic [PTR_W-1:0] k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ clients.
// Each client posts one read or write word; the arbiter pulses the master's
// level-sensitive command, follows CS low then high to find the end of the
// transfer, returns miso_data and pulses done to the owner.
//   clk, rst_n            : clock, async active-low reset
//   req/req_rd/req_wdata  : per-client request, read flag, write word
//   gnt/done              : one-hot owner, one-cycle completion pulse
//   rdata                 : read word, valid with done, held until next read
//   busy                  : FSM not idle
//   timeout_err           : watchdog abort pulse
//   spi_wr_cmd/spi_rd_cmd/mosi_data : to spi_master
//   miso_data/spi_cs      : from spi_master
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable the WAIT_START/WAIT_END
// watchdog (TIMEOUT_CYC); otherwise timeout_err is tied 0.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SPI_WIDTH   = 8,
    parameter int unsigned CMD_HOLD    = 2,
    parameter int unsigned GAP_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_rd,
    input  logic [NUM_REQ*SPI_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [SPI_WIDTH-1:0]           rdata,
    output logic                           busy,
    output logic                           timeout_err,
    output logic                           spi_wr_cmd,
    output logic                           spi_rd_cmd,
    output logic [SPI_WIDTH-1:0]           mosi_data,
    input  logic [SPI_WIDTH-1:0]           miso_data,
    input  logic                           spi_cs
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(CMD_HOLD, GAP_CYCLES, TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CMD_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    logic                   to_q;
`endif

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       ptr_q, idx_q, pick_idx;
    logic [NUM_REQ-1:0]     owner_q, pick_gnt;
    logic                   pick_valid;
    logic                   rd_q;
    logic                   to_d;
    logic [SPI_WIDTH-1:0]   wdata_q, rdata_q;

    spi_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        to_d    = 1'b0;
        unique case (state_q)
            ST_IDLE:       if (pick_valid) state_d = ST_CMD;
            ST_CMD:        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (!spi_cs) state_d = ST_WAIT_END;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end
`endif
            end
            ST_WAIT_END: begin
                if (spi_cs) state_d = ST_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                end
`endif
            end
            ST_DONE:       state_d = ST_GAP;
            ST_GAP:        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        // One counter serves all timed states; the watchdog spans both WAIT
        // states, so it is not cleared on WAIT_START -> WAIT_END.
        cnt_d = cnt_q;
        if (state_d != state_q &&
            !(state_q == ST_WAIT_START && state_d == ST_WAIT_END))
            cnt_d = '0;
        else if (state_q == ST_CMD || state_q == ST_GAP)
            cnt_d = cnt_q + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (state_q == ST_WAIT_START || state_q == ST_WAIT_END)
            cnt_d = cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            owner_q <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= to_d;
`endif
            if (state_q == ST_IDLE && pick_valid) begin
                idx_q   <= pick_idx;
                owner_q <= pick_gnt;
                rd_q    <= req_rd[pick_idx];
                wdata_q <= req_rd[pick_idx] ? '0
                         : req_wdata[32'(pick_idx)*SPI_WIDTH +: SPI_WIDTH];
            end
            // Capture on entry to DONE so rdata is already valid with done.
            if (state_d == ST_DONE && !to_d && rd_q)
                rdata_q <= miso_data;
            if (state_q == ST_DONE)
                ptr_q <= (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign gnt        = (state_q == ST_CMD || state_q == ST_WAIT_START ||
                         state_q == ST_WAIT_END) ? owner_q : '0;
    assign done       = (state_q == ST_DONE) ? owner_q : '0;
    assign spi_wr_cmd = (state_q == ST_CMD) && !rd_q;
    assign spi_rd_cmd = (state_q == ST_CMD) && rd_q;
    assign mosi_data  = wdata_q;
    assign rdata      = rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_err = (state_q == ST_DONE) && to_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

    localparam int GAP = 8;
    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req_rd, gnt, done;
    logic [31:0] req_wdata;
    logic [7:0]  rdata, mosi_data, miso_data;
    logic        busy, timeout_err, spi_wr_cmd, spi_rd_cmd, spi_cs;

    spi_master_arbiter #(
        .NUM_REQ     (4),
        .SPI_WIDTH   (8),
        .CMD_HOLD    (HOLD),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_rd      (req_rd),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .busy        (busy),
        .timeout_err (timeout_err),
        .spi_wr_cmd  (spi_wr_cmd),
        .spi_rd_cmd  (spi_rd_cmd),
        .mosi_data   (mosi_data),
        .miso_data   (miso_data),
        .spi_cs      (spi_cs)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state: rotation pointer and last read word.
    int         m_ptr = 0;
    logic [7:0] m_rdata = '0;

    function automatic int m_pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (p + i) % 4;
            if (m[k]) return k;
        end
        return 0;
    endfunction

    // Slave model standing in for spi_master: CS low two cycles after a
    // command is seen, high again six cycles later with the response word.
    logic       slave_en = 1'b1;
    logic [7:0] slave_miso = '0;
    initial begin
        spi_cs = 1'b1;
        miso_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && slave_en && (spi_wr_cmd || spi_rd_cmd)) begin
                repeat (2) @(posedge clk);
                #1 spi_cs = 1'b0;
                repeat (6) @(posedge clk);
                #1 miso_data = slave_miso;
                spi_cs = 1'b1;
            end
        end
    end

    // Protocol monitor: exclusive cmds, one-hot grant, cmd width, CS-to-cmd gap.
    int cyc = 0, last_cs_rise = -1, hold = 0;
    bit prev_cmd = 0, prev_cs = 1, exact_gap = 0;
    always @(negedge clk) begin
        bit cur;
        cyc++;
        if (!rst_n) begin
            prev_cmd = 0; prev_cs = 1; hold = 0; last_cs_rise = -1;
        end else begin
            cur = spi_wr_cmd | spi_rd_cmd;
            check("one_cmd", 32'(spi_wr_cmd & spi_rd_cmd), 32'd0);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (cur && !prev_cmd) begin
                if (last_cs_rise >= 0) begin
                    if (exact_gap) check("gap_exact", 32'(cyc - last_cs_rise), 32'(GAP + 3));
                    else           check("gap_min", 32'(cyc - last_cs_rise >= GAP), 32'd1);
                end
                hold = 1;
            end else if (cur) hold++;
            else if (prev_cmd) check("cmd_hold", 32'(hold), 32'(HOLD));
            if (spi_cs && !prev_cs) last_cs_rise = cyc;
            prev_cmd = cur;
            prev_cs = spi_cs;
        end
    end

    // what: 0=cmd high, 1=done pulse, 2=idle, 3=CS low
    task automatic wait_until(input int what, input int budget, input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (what)
                0: ok = spi_wr_cmd | spi_rd_cmd;
                1: ok = (done != '0);
                2: ok = !busy;
                3: ok = !spi_cs;
                default: ok = 1;
            endcase
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: not reached within %0d cycles", tag, budget);
        end
    endtask

    task automatic run_txn(input logic [3:0] mask, input logic [3:0] rd, input logic [31:0] wd,
                           input logic [7:0] miso, input logic [3:0] exp_gnt,
                           input logic [7:0] exp_mosi, input logic [7:0] exp_rdata,
                           input string tag);
        bit ok;
        int own;
        own = 0;
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) own = i;
        @(posedge clk);
        #1 slave_miso = miso; req_rd = rd; req_wdata = wd; req = mask;
        @(negedge clk);
        check({tag, "_gnt_before"}, 32'(gnt), 32'd0);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_cmd"}, 32'({spi_rd_cmd, spi_wr_cmd}), rd[own] ? 32'd2 : 32'd1);
        check({tag, "_mosi"}, 32'(mosi_data), 32'(exp_mosi));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_until(1, 100, {tag, "_done"}, ok);
        if (ok) begin
            check({tag, "_done"}, 32'(done), 32'(exp_gnt));
            check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
            check({tag, "_gnt_at_done"}, 32'(gnt), 32'd0);
            check({tag, "_terr"}, 32'(timeout_err), 32'd0);
        end
        m_ptr = (own + 1) % 4;
        m_rdata = exp_rdata;
        @(posedge clk);
        #1 req = '0;
        wait_until(2, 100, {tag, "_idle"}, ok);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  rd;
        logic [31:0] wd;
        logic [7:0]  miso;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_mosi;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok, seen;
        int own, n;
        logic [3:0]  mask, rd;
        logic [31:0] wd;
        logic [7:0]  miso, emosi, erd;

        vecs[0] = '{4'b0001, 4'b0000, 32'h000000A5, 8'h5A, 4'b0001, 8'hA5, 8'h00};
        vecs[1] = '{4'b0100, 4'b0100, 32'h00770000, 8'h3C, 4'b0100, 8'h00, 8'h3C};
        vecs[2] = '{4'b0010, 4'b0000, 32'h00000F00, 8'hFF, 4'b0010, 8'h0F, 8'h3C};
        vecs[3] = '{4'b1000, 4'b1000, 32'h00000000, 8'hC3, 4'b1000, 8'h00, 8'hC3};
        vecs[4] = '{4'b0001, 4'b0001, 32'h000000FF, 8'h00, 4'b0001, 8'h00, 8'h00};
        vecs[5] = '{4'b1000, 4'b0000, 32'h81000000, 8'h99, 4'b1000, 8'h81, 8'h00};
        vecs[6] = '{4'b0110, 4'b0000, 32'h00442200, 8'h11, 4'b0010, 8'h22, 8'h00};
        vecs[7] = '{4'b0101, 4'b0101, 32'h00000000, 8'hE7, 4'b0100, 8'h00, 8'hE7};
        vecs[8] = '{4'b1000, 4'b0000, 32'h5A000000, 8'h00, 4'b1000, 8'h5A, 8'hE7};

        rst_n = 1'b0; req = '0; req_rd = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmds", 32'({spi_rd_cmd, spi_wr_cmd}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mosi", 32'(mosi_data), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].mask, vecs[i].rd, vecs[i].wd, vecs[i].miso, vecs[i].exp_gnt,
                    vecs[i].exp_mosi, vecs[i].exp_rdata, $sformatf("vec%0d", i));

        // Contention: all four held, strict rotation, back-to-back gap.
        @(posedge clk);
        #1 req_rd = '0; req_wdata = 32'hD4C3B2A1; req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            own = m_pick(req, m_ptr);
            wait_until(0, 200, "cont_cmd", ok);
            check($sformatf("cont%0d_gnt", k), 32'(gnt), 32'd1 << own);
            check($sformatf("cont%0d_mosi", k), 32'(mosi_data), 32'(req_wdata[own*8 +: 8]));
            wait_until(1, 100, "cont_done", ok);
            check($sformatf("cont%0d_done", k), 32'(done), 32'd1 << own);
            m_ptr = (own + 1) % 4;
            exact_gap = 1;
        end
        exact_gap = 0;
        @(posedge clk);
        #1 req = '0;
        wait_until(2, 100, "cont_idle", ok);

        // Fairness: client 3 joins during client 1's transfer.
        @(posedge clk);
        #1 req_wdata = 32'h44332211; req = 4'b0010;
        wait_until(0, 50, "fair_cmd1", ok);
        check("fair_gnt1", 32'(gnt), 32'd1 << m_pick(4'b0010, m_ptr));
        @(posedge clk);
        #1 req = 4'b1010;
        wait_until(1, 100, "fair_done1", ok);
        check("fair_done1", 32'(done), 32'b0010);
        m_ptr = 2;
        wait_until(0, 100, "fair_cmd3", ok);
        check("fair_gnt3", 32'(gnt), 32'd1 << m_pick(4'b1010, m_ptr));
        wait_until(1, 100, "fair_done3", ok);
        check("fair_done3", 32'(done), 32'b1000);
        m_ptr = 0;
        @(posedge clk);
        #1 req = 4'b0010;
        wait_until(0, 100, "fair_cmd1b", ok);
        check("fair_gnt1b", 32'(gnt), 32'b0010);
        wait_until(1, 100, "fair_done1b", ok);
        check("fair_done1b", 32'(done), 32'b0010);
        m_ptr = 2;
        @(posedge clk);
        #1 req = '0;
        wait_until(2, 100, "fair_idle", ok);

        // Abandon: request dropped during WAIT_END.
        @(posedge clk);
        #1 req = 4'b0010;
        wait_until(0, 50, "ab_cmd", ok);
        check("ab_gnt", 32'(gnt), 32'b0010);
        wait_until(3, 50, "ab_cs", ok);
        @(negedge clk);
        @(posedge clk);
        #1 req = '0;
        wait_until(1, 100, "ab_done", ok);
        check("ab_done", 32'(done), 32'b0010);
        m_ptr = 2;
        wait_until(2, 100, "ab_idle", ok);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_wr_cmd || spi_rd_cmd || busy) seen = 1;
        end
        check("ab_no_reissue", 32'(seen), 32'd0);

        // Reset during WAIT_END.
        @(posedge clk);
        #1 req_rd = '0; req = 4'b0001;
        wait_until(0, 50, "rst_cmd", ok);
        wait_until(3, 50, "rst_cs", ok);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_cmds", 32'({spi_rd_cmd, spi_wr_cmd}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        req = '0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ptr = 0;
        m_rdata = '0;
        run_txn(4'b0001, 4'b0001, 32'h0, 8'h96, 4'b0001, 8'h00, 8'h96, "post_rst");

        // Randomised traffic against the rotation model.
        for (int t = 0; t < 30; t++) begin
            mask = 4'($urandom_range(1, 15));
            rd = 4'($urandom);
            wd = $urandom;
            miso = 8'($urandom);
            own = m_pick(mask, m_ptr);
            emosi = rd[own] ? 8'h00 : wd[own*8 +: 8];
            erd = rd[own] ? miso : m_rdata;
            run_txn(mask, rd, wd, miso, 4'(1 << own), emosi, erd, $sformatf("rnd%0d", t));
        end

        // Slave never asserts CS.
        slave_en = 1'b0;
        @(posedge clk);
        #1 req_rd = '0; req_wdata = 32'h00AB0000; req = 4'b0100;
        wait_until(0, 50, "to_cmd", ok);
`ifdef SPI_ARB_TIMEOUT_EN
        n = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (done != '0) begin seen = 1; break; end
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_latency", 32'(n), 32'd18);
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_done", 32'(done), 32'b0100);
        check("to_rdata", 32'(rdata), 32'(m_rdata));
`else
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done != '0 || timeout_err) seen = 1;
        end
        check("stall_no_done", 32'(seen), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_gnt", 32'(gnt), 32'b0100);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
